// File: rtl/mem_stage_unit.sv
// Memory-access pipeline stage: latches the EX_to_ME bus, extracts and extends
// load data from the synchronous data SRAM, and feeds WB plus ID forwarding.
module mem_stage_unit (
   input  logic        clk,
   input  logic        resetn,
   input  logic        EX_to_ME_Valid,
   input  logic [75:0] EX_to_ME_Bus,
   output logic        ME_Allow_in,
   input  logic [31:0] data_sram_rdata,
   output logic        ME_to_WB_Valid,
   input  logic        WB_Allow_in,
   output logic [69:0] ME_to_WB_Bus,
   output logic [4:0]  ME_dest,
   output logic [31:0] ME_Forward_Res
);

   logic        me_valid;
   logic        first_cycle;
   logic [75:0] me_bus;
   logic [31:0] rdata_hold;
   logic        accept;

   logic        src_is_signed;
   logic        mem_is_byte;
   logic        mem_is_half;
   logic [1:0]  mem_offset;
   logic [31:0] me_pc;
   logic [31:0] alu_result;
   logic        res_from_mem;
   logic        gr_we;
   logic [4:0]  dest;

   logic [31:0] eff_rdata;
   logic [7:0]  load_b;
   logic [15:0] load_h;
   logic [31:0] load_data;
   logic [31:0] final_result;

   assign ME_Allow_in    = !me_valid || WB_Allow_in;
   assign accept         = ME_Allow_in && EX_to_ME_Valid;
   assign ME_to_WB_Valid = me_valid;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         me_valid    <= 1'b0;
         first_cycle <= 1'b0;
         me_bus      <= '0;
         rdata_hold  <= '0;
      end else begin
         if (ME_Allow_in) begin
            me_valid <= EX_to_ME_Valid;
         end
         if (accept) begin
            me_bus <= EX_to_ME_Bus;
         end
         first_cycle <= accept;
         // SRAM output only reflects this load's address in the first cycle;
         // keep a copy so stalls of any length return the same data.
         if (me_valid && first_cycle) begin
            rdata_hold <= data_sram_rdata;
         end
      end
   end

   assign src_is_signed = me_bus[75];
   assign mem_is_byte   = me_bus[74];
   assign mem_is_half   = me_bus[73];
   assign mem_offset    = me_bus[72:71];
   assign me_pc         = me_bus[70:39];
   assign alu_result    = me_bus[38:7];
   assign res_from_mem  = me_bus[6];
   assign gr_we         = me_bus[5];
   assign dest          = me_bus[4:0];

   assign eff_rdata = first_cycle ? data_sram_rdata : rdata_hold;

   always_comb begin
      load_b = eff_rdata[7:0];
      case (mem_offset)
         2'd0:    load_b = eff_rdata[7:0];
         2'd1:    load_b = eff_rdata[15:8];
         2'd2:    load_b = eff_rdata[23:16];
         default: load_b = eff_rdata[31:24];
      endcase
   end

   assign load_h = mem_offset[1] ? eff_rdata[31:16] : eff_rdata[15:0];

   // Encoding 11 is never issued by EX and falls through to the word path.
   always_comb begin
      load_data = eff_rdata;
      case ({mem_is_byte, mem_is_half})
         2'b10:   load_data = src_is_signed ? {{24{load_b[7]}}, load_b}
                                            : {24'b0, load_b};
         2'b01:   load_data = src_is_signed ? {{16{load_h[15]}}, load_h}
                                            : {16'b0, load_h};
         default: load_data = eff_rdata;
      endcase
   end

   assign final_result   = res_from_mem ? load_data : alu_result;
   assign ME_Forward_Res = final_result;
   assign ME_to_WB_Bus   = {me_pc, final_result, gr_we, dest};
   assign ME_dest        = dest & {5{me_valid}} & {5{gr_we}};

endmodule

// File: doc/mem_stage_unit.md
Name: mem_stage_unit

Overview:
Memory-access pipeline stage; consumer end of the EX-to-ME interface. Accepts the 76-bit EX_to_ME bus under the valid/allow-in handshake and takes the synchronous data-SRAM read response. Extracts and extends load data, then drives the ME-to-WB bus plus ME forwarding and hazard outputs back to ID.

Parameters:
None. All bus widths are fixed by the EX and WB stage contracts.

Ports:
clk  in  1  core clock; all state updates on the rising edge
resetn  in  1  asynchronous active-low reset
EX_to_ME_Valid  in  1  EX holds a completed instruction
EX_to_ME_Bus  in  76  [75:71] dest_flag={src_is_signed,mem_is_byte,mem_is_half,offset[1:0]}, [70:39] pc, [38:7] alu_result, [6] res_from_mem, [5] gr_we, [4:0] dest
ME_Allow_in  out  1  ME can accept a new instruction this cycle
data_sram_rdata  in  32  SRAM read data; valid only in the cycle after the EX-stage request
ME_to_WB_Valid  out  1  ME holds a valid instruction for WB
WB_Allow_in  in  1  WB can accept this cycle
ME_to_WB_Bus  out  70  [69:38] pc, [37:6] final_result, [5] gr_we, [4:0] dest
ME_dest  out  5  destination register for the ID hazard check; 0 when not writing
ME_Forward_Res  out  32  final_result, forwarded to ID

Behaviour:
- Handshake: ME_ReadyGo=1. ME_Allow_in = !ME_Valid || WB_Allow_in. ME_to_WB_Valid = ME_Valid.
- ME_Valid: async-cleared by resetn. Otherwise, when ME_Allow_in=1, loads EX_to_ME_Valid on each clk edge.
- Payload registers load EX_to_ME_Bus only when ME_Allow_in && EX_to_ME_Valid. They hold otherwise, including while ME is stalled.
- first_cycle flag: set to 1 on an accepting edge. Cleared on any other edge.
- rdata_hold register: captures data_sram_rdata on the edge ending a cycle with ME_Valid && first_cycle.
- Load data source: eff_rdata = first_cycle ? data_sram_rdata : rdata_hold.
  - EX drives a new SRAM address every cycle, so rdata is only trustworthy in the first residency cycle.
  - A stall of any length must therefore not change the result.
- Load extraction, selected by {mem_is_byte, mem_is_half}:
  - 10 (byte): b = eff_rdata[8*offset +: 8]. Result = src_is_signed ? {{24{b[7]}},b} : {24'b0,b}.
  - 01 (half): h = offset[1] ? eff_rdata[31:16] : eff_rdata[15:0]. Sign- or zero-extend to 32 bits by src_is_signed.
  - 00 (word): eff_rdata unchanged; offset is ignored.
  - 11: never issued by EX; treat as word.
- Half loads use offset[1] only. Misaligned accesses are not raised as exceptions in this core.
- final_result = res_from_mem ? load_data : alu_result. Purely combinational from the registers and eff_rdata; no extra cycle of latency.
- ME_dest = dest & {5{ME_Valid}} & {5{gr_we}}.
- ME_Forward_Res = final_result, driven regardless of ME_Valid. ID qualifies it with ME_dest.
- Latency: an instruction accepted at edge N is presented to WB during cycle N..N+1. It transfers at the first edge where WB_Allow_in=1.
- Simultaneous events: when ME_Valid=1 and WB_Allow_in=1 and EX_to_ME_Valid=1 on the same edge, the old instruction leaves and the new one is latched (full throughput, no bubble).
- Bubble: when ME_Allow_in=1 and EX_to_ME_Valid=0, ME_Valid goes to 0 and the payload holds stale data, which no consumer may use.
- Reset, including mid-operation: async clear of ME_Valid, first_cycle, all payload registers and rdata_hold to 0. While resetn=0:
  - ME_Allow_in=1
  - ME_to_WB_Valid=0
  - ME_dest=0
  - ME_to_WB_Bus=0 (when data_sram_rdata is not selected)
- An in-flight instruction is discarded; nothing is replayed after reset release.

Test Plan:
- ld.b signed: bus flag=5'b11011, res_from_mem=1, gr_we=1, dest=5; rdata=0x80FF1234 in first cycle -> final_result=0xFFFFFF80, ME_dest=5.
- ld.hu: flag=5'b00110, rdata=0x80017FFF -> final_result=0x00008001. With flag=5'b00100 -> 0x00007FFF.
- Stall hold: ld.w with rdata=0xDEADBEEF, then WB_Allow_in=0 for 3 cycles while rdata toggles to 0x12345678 -> ME_to_WB_Bus result stays 0xDEADBEEF, ME_Allow_in=0, and it transfers on the first edge with WB_Allow_in=1.
- Back-to-back: add (alu_result=0x11) followed by ld.w, both with WB_Allow_in=1 and EX valid every cycle -> WB sees 0x11 then the load data on consecutive cycles; ME_Valid never drops.
- Non-writing op: gr_we=0, dest=7 -> ME_dest=0, and final_result equals alu_result when res_from_mem=0.
- Reset mid-stall: assert resetn=0 asynchronously between edges with ME_Valid=1 -> ME_to_WB_Valid=0 and ME_dest=0 immediately. After release, ME_Allow_in=1 and the first accepted instruction completes normally.
